// File: rtl/io_port_arbiter.sv
// Arbitrates the data-memory B port between the VGA scan-out reader and the PS2 keyboard.
// VGA has fixed priority; a saturating wait counter forces a keyboard grant when it starves.
module io_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned MAX_WAIT     = 15
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic                  vga_gnt,
    output logic                  vga_rvalid,
    output logic [DATA_WIDTH-1:0] vga_rdata,

    input  logic                  kbd_req,
    input  logic                  kbd_we,
    input  logic [ADDR_WIDTH-1:0] kbd_addr,
    input  logic [DATA_WIDTH-1:0] kbd_wdata,
    output logic                  kbd_gnt,
    output logic                  kbd_rvalid,
    output logic [DATA_WIDTH-1:0] kbd_rdata,

    output logic [ADDR_WIDTH-1:0] io_addr,
    output logic                  io_wren,
    output logic [DATA_WIDTH-1:0] io_wdata,
    input  logic [DATA_WIDTH-1:0] io_rdata,

    output logic                  starved
);

    localparam int unsigned STAGES       = READ_LATENCY + 1;
    localparam logic [7:0]  MAX_WAIT_CNT = 8'(MAX_WAIT);

    logic [7:0]            wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] io_addr_q;
    logic                  io_wren_q;
    logic [DATA_WIDTH-1:0] io_wdata_q;
    logic [STAGES-1:0]     pipe_valid_q;
    logic [STAGES-1:0]     pipe_kbd_q;
    logic [DATA_WIDTH-1:0] vga_rdata_q, kbd_rdata_q;
    logic                  push_valid;
    logic                  ret_valid;

    assign starved = (wait_q == MAX_WAIT_CNT);

    // Grants are combinational; a starved keyboard overrides VGA priority.
    always_comb begin
        vga_gnt = 1'b0;
        kbd_gnt = 1'b0;
        if (!rst) begin
            if (kbd_req && (starved || !vga_req)) begin
                kbd_gnt = 1'b1;
            end else if (vga_req) begin
                vga_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!kbd_req || kbd_gnt) begin
            wait_d = 8'd0;
        end else if (!starved) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end

    // Command stream toward the memory; address/data hold when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_addr_q  <= '0;
            io_wren_q  <= 1'b0;
            io_wdata_q <= '0;
        end else begin
            io_wren_q <= kbd_gnt & kbd_we;
            if (kbd_gnt) begin
                io_addr_q  <= kbd_addr;
                io_wdata_q <= kbd_wdata;
            end else if (vga_gnt) begin
                io_addr_q <= vga_addr;
            end
        end
    end

    assign io_addr  = io_addr_q;
    assign io_wren  = io_wren_q;
    assign io_wdata = io_wdata_q;

    // Return tracking: one slot per cycle in flight, tail lines up with io_rdata.
    assign push_valid = vga_gnt | (kbd_gnt & ~kbd_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_q <= '0;
            pipe_kbd_q   <= '0;
        end else begin
            pipe_valid_q <= {pipe_valid_q[STAGES-2:0], push_valid};
            pipe_kbd_q   <= {pipe_kbd_q[STAGES-2:0], kbd_gnt};
        end
    end

    assign ret_valid  = pipe_valid_q[STAGES-1] & ~rst;
    assign vga_rvalid = ret_valid & ~pipe_kbd_q[STAGES-1];
    assign kbd_rvalid = ret_valid & pipe_kbd_q[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_rdata_q <= '0;
            kbd_rdata_q <= '0;
        end else begin
            if (vga_rvalid) begin
                vga_rdata_q <= io_rdata;
            end
            if (kbd_rvalid) begin
                kbd_rdata_q <= io_rdata;
            end
        end
    end

    // Pass memory data straight through on the pulse, then hold the captured copy.
    assign vga_rdata = vga_rvalid ? io_rdata : vga_rdata_q;
    assign kbd_rdata = kbd_rvalid ? io_rdata : kbd_rdata_q;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Directed bench for io_port_arbiter: a memory stand-in on the B port, a transaction-level
// reference model checked every cycle, and hand-computed literal checks along the way.
module tb_io_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 2;
    localparam int unsigned MW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_req, vga_gnt, vga_rvalid;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_rdata;
    logic          kbd_req, kbd_we, kbd_gnt, kbd_rvalid;
    logic [AW-1:0] kbd_addr;
    logic [DW-1:0] kbd_wdata, kbd_rdata;
    logic [AW-1:0] io_addr;
    logic          io_wren;
    logic [DW-1:0] io_wdata, io_rdata;
    logic          starved;

    int vectors = 0;
    int miscompares = 0;

    io_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .READ_LATENCY(RL),
        .MAX_WAIT    (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_gnt   (vga_gnt),
        .vga_rvalid(vga_rvalid),
        .vga_rdata (vga_rdata),
        .kbd_req   (kbd_req),
        .kbd_we    (kbd_we),
        .kbd_addr  (kbd_addr),
        .kbd_wdata (kbd_wdata),
        .kbd_gnt   (kbd_gnt),
        .kbd_rvalid(kbd_rvalid),
        .kbd_rdata (kbd_rdata),
        .io_addr   (io_addr),
        .io_wren   (io_wren),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .starved   (starved)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    // Memory stand-in: address registered at the edge, data RL cycles later.
    logic [31:0] ram [512];
    logic        ram_ready = 1'b0;
    logic [31:0] ap0, ap1;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else if (io_wren) begin
            ram[io_addr[8:0]] <= io_wdata;
        end
        ap0 <= io_addr;
        ap1 <= ap0;
    end

    assign io_rdata = ram[ap1[8:0]];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Reference model: grant rules, a wait count, and a queue of timed returns.
    typedef struct {
        int          due;
        logic        kbd;
        logic [31:0] data;
    } ret_t;

    initial begin
        ret_t        pend[$];
        logic [31:0] mmem [512];
        int          cyc = 0;
        int          wcnt = 0;
        logic [31:0] m_addr = 0, m_wdata = 0, m_vrd = 0, m_krd = 0;
        logic        m_wren = 0;
        logic        eg_v, eg_k, ev_v, ev_k;
        logic [31:0] edata;
        for (int i = 0; i < 512; i++) mmem[i] = init_word(i);
        forever begin
            @(negedge clk);
            cyc++;
            eg_v = 1'b0;
            eg_k = 1'b0;
            if (!rst) begin
                eg_k = kbd_req && ((wcnt == MW) || !vga_req);
                eg_v = vga_req && !eg_k;
            end
            chk("vga_gnt", {31'd0, vga_gnt}, {31'd0, eg_v});
            chk("kbd_gnt", {31'd0, kbd_gnt}, {31'd0, eg_k});
            chk("starved", {31'd0, starved}, {31'd0, wcnt == MW});
            chk("io_addr", io_addr, m_addr);
            chk("io_wren", {31'd0, io_wren}, {31'd0, m_wren});
            chk("io_wdata", io_wdata, m_wdata);

            ev_v = 1'b0;
            ev_k = 1'b0;
            edata = 32'd0;
            if (!rst && pend.size() > 0 && pend[0].due == cyc) begin
                ev_v = !pend[0].kbd;
                ev_k = pend[0].kbd;
                edata = pend[0].data;
            end
            chk("vga_rvalid", {31'd0, vga_rvalid}, {31'd0, ev_v});
            chk("kbd_rvalid", {31'd0, kbd_rvalid}, {31'd0, ev_k});
            chk("vga_rdata", vga_rdata, ev_v ? edata : m_vrd);
            chk("kbd_rdata", kbd_rdata, ev_k ? edata : m_krd);
            chk("both_rvalid", {31'd0, vga_rvalid & kbd_rvalid}, 32'd0);

            if (rst) begin
                wcnt = 0;
                m_addr = 0;
                m_wren = 0;
                m_wdata = 0;
                m_vrd = 0;
                m_krd = 0;
                pend.delete();
            end else begin
                if (ev_v) m_vrd = edata;
                if (ev_k) m_krd = edata;
                if (ev_v || ev_k) void'(pend.pop_front());
                if (!kbd_req || eg_k) wcnt = 0;
                else if (wcnt < MW) wcnt++;
                m_wren = eg_k && kbd_we;
                if (eg_v) begin
                    m_addr = vga_addr;
                    pend.push_back('{cyc + 1 + RL, 1'b0, mmem[vga_addr[8:0]]});
                end
                if (eg_k) begin
                    m_addr = kbd_addr;
                    m_wdata = kbd_wdata;
                    if (kbd_we) mmem[kbd_addr[8:0]] = kbd_wdata;
                    else pend.push_back('{cyc + 1 + RL, 1'b1, mmem[kbd_addr[8:0]]});
                end
            end
        end
    end

    task automatic set_in(input logic vr, input logic [31:0] va, input logic kr,
                          input logic kw, input logic [31:0] ka, input logic [31:0] kd);
        vga_req = vr;
        vga_addr = va;
        kbd_req = kr;
        kbd_we = kw;
        kbd_addr = ka;
        kbd_wdata = kd;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        // Single VGA read of 0x40
        rst = 1'b0;
        set_in(1, 32'h40, 0, 0, 0, 0);
        chk("lit_reset_io_addr", io_addr, 32'h0);
        chk("lit_reset_io_wren", {31'd0, io_wren}, 32'd0);
        chk("lit_reset_starved", {31'd0, starved}, 32'd0);
        chk("lit_reset_vga_rdata", vga_rdata, 32'h0);
        chk("lit_reset_kbd_rdata", kbd_rdata, 32'h0);
        chk("lit_vga_gnt_c0", {31'd0, vga_gnt}, 32'd1);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("lit_io_addr_c1", io_addr, 32'h40);
        chk("lit_io_wren_c1", {31'd0, io_wren}, 32'd0);
        tick();
        tick();
        chk("lit_vga_rvalid_c3", {31'd0, vga_rvalid}, 32'd1);
        chk("lit_vga_rdata_c3", vga_rdata, 32'h1000_0040);
        tick();

        // Keyboard write then read-back of 0x100
        set_in(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF);
        chk("lit_kbd_wr_gnt", {31'd0, kbd_gnt}, 32'd1);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("lit_wren_pulse", {31'd0, io_wren}, 32'd1);
        chk("lit_wr_addr", io_addr, 32'h100);
        chk("lit_wr_data", io_wdata, 32'hDEAD_BEEF);
        tick();
        chk("lit_wren_drop", {31'd0, io_wren}, 32'd0);
        tick();
        tick();
        set_in(0, 0, 1, 0, 32'h100, 0);
        chk("lit_kbd_rd_gnt", {31'd0, kbd_gnt}, 32'd1);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("lit_kbd_rvalid", {31'd0, kbd_rvalid}, 32'd1);
        chk("lit_kbd_rdata", kbd_rdata, 32'hDEAD_BEEF);
        tick();

        // Continuous VGA traffic starves a pending keyboard read
        for (int i = 0; i <= 15; i++) begin
            set_in(1, 32'h10 + 32'(i), 1, 0, 32'h5, 0);
            if (i < 15) begin
                chk("lit_kbd_denied", {31'd0, kbd_gnt}, 32'd0);
                chk("lit_not_starved", {31'd0, starved}, 32'd0);
            end else begin
                chk("lit_starved_15", {31'd0, starved}, 32'd1);
                chk("lit_forced_kbd", {31'd0, kbd_gnt}, 32'd1);
                chk("lit_forced_vga", {31'd0, vga_gnt}, 32'd0);
            end
            tick();
        end
        set_in(1, 32'h30, 0, 0, 0, 0);
        chk("lit_vga_back", {31'd0, vga_gnt}, 32'd1);
        chk("lit_starved_clr", {31'd0, starved}, 32'd0);
        tick();
        set_in(1, 32'h31, 1, 0, 32'h6, 0);
        chk("lit_vga_prio", {31'd0, vga_gnt}, 32'd1);
        tick();
        set_in(0, 0, 1, 0, 32'h6, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (4) tick();

        // Alternating owners, one read per cycle
        for (int i = 0; i < 8; i++) begin
            set_in(i % 2 == 0, 32'(i), i % 2 == 1, 0, 32'(i), 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("lit_alt_kbd_rvalid", {31'd0, kbd_rvalid}, 32'd1);
        chk("lit_alt_kbd_rdata", kbd_rdata, 32'h1000_0007);
        chk("lit_alt_vga_hold", vga_rdata, 32'h1000_0006);
        repeat (3) tick();

        // Reset with two VGA reads in flight
        set_in(1, 32'h20, 0, 0, 0, 0);
        tick();
        set_in(1, 32'h21, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        set_in(1, 32'h22, 0, 0, 0, 0);
        chk("lit_rst_no_gnt", {31'd0, vga_gnt}, 32'd0);
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            chk("lit_post_rst_rvalid", {31'd0, vga_rvalid}, 32'd0);
            chk("lit_post_rst_vga_rdata", vga_rdata, 32'h0);
            chk("lit_post_rst_kbd_rdata", kbd_rdata, 32'h0);
            chk("lit_post_rst_io_addr", io_addr, 32'h0);
            tick();
        end

        // Idle period after a write: outputs hold
        set_in(0, 0, 1, 1, 32'h1F, 32'h1234_5678);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("lit_idle_pulse", {31'd0, io_wren}, 32'd1);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("lit_idle_wren", {31'd0, io_wren}, 32'd0);
            chk("lit_idle_addr", io_addr, 32'h1F);
            chk("lit_idle_starved", {31'd0, starved}, 32'd0);
            tick();
        end
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
